// File: rtl/temp_scan_scheduler_if.sv
// Bus bundle for temp_scan_scheduler: configuration writes, the sensor
// sample handshake, the shared abnormality datapath and the alarm outputs.
//
// Sample handshake: the scheduler raises sampleReq with sampleCh stable and
// holds both until the sensor answers. A sample transfers on a rising clock
// edge where sampleReq and sampleAck are both high, and sampleData is taken
// on that edge. sampleAck while sampleReq is low is ignored.
interface temp_scan_scheduler_if;
  logic       scanEn;
  logic       cfgWe;
  logic [1:0] cfgCh;
  logic [4:0] cfgBase;
  logic [3:0] cfgCoef;
  logic       sampleReq;
  logic [1:0] sampleCh;
  logic       sampleAck;
  logic [3:0] sampleData;
  logic [4:0] dpBaseTemp;
  logic [3:0] dpTempCoef;
  logic [3:0] dpSensorValue;
  logic       dpAbnormality;
  logic [3:0] alarmClr;
  logic [3:0] alarm;
  logic       scanDone;
  logic [1:0] state;

  // Scheduler side
  modport master (
    input  scanEn, cfgWe, cfgCh, cfgBase, cfgCoef,
    input  sampleAck, sampleData, dpAbnormality, alarmClr,
    output sampleReq, sampleCh, dpBaseTemp, dpTempCoef, dpSensorValue,
    output alarm, scanDone, state
  );

  // Environment side (sensor, datapath, host)
  modport slave (
    output scanEn, cfgWe, cfgCh, cfgBase, cfgCoef,
    output sampleAck, sampleData, dpAbnormality, alarmClr,
    input  sampleReq, sampleCh, dpBaseTemp, dpTempCoef, dpSensorValue,
    input  alarm, scanDone, state
  );
endinterface

// File: rtl/temp_scan_scheduler.sv
// temp_scan_scheduler: round-robin scan of four temperature channels.
// Each channel is requested from the sensor, its calibration entry and raw
// value are registered onto the shared datapath, and the datapath's
// abnormality result feeds a per-channel 2-bit debounce that drives alarm.
// Optional macro STICKY_ALARM_EN: a set alarm latches until alarmClr.
module temp_scan_scheduler (
  input logic                   clk,
  input logic                   rstN,
  temp_scan_scheduler_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_EVAL   = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  logic [1:0] state;
  logic [1:0] ch;
  logic [4:0] base_tbl [4];
  logic [3:0] coef_tbl [4];
  logic [1:0] cnt      [4];
  logic [1:0] cnt_nxt  [4];
  logic [3:0] alarm;
  logic [3:0] alarm_nxt;
  logic [3:0] sel_ch;
  logic       scan_done;
  logic [4:0] dp_base;
  logic [3:0] dp_coef;
  logic [3:0] dp_value;
  logic       take;
  logic       upd;

  assign take = (state == S_REQ) && bus.sampleAck;
  assign upd  = (state == S_UPDATE);

  assign bus.sampleReq     = (state == S_REQ);
  assign bus.sampleCh      = ch;
  assign bus.dpBaseTemp    = dp_base;
  assign bus.dpTempCoef    = dp_coef;
  assign bus.dpSensorValue = dp_value;
  assign bus.alarm         = alarm;
  assign bus.scanDone      = scan_done;
  assign bus.state         = state;

`ifndef STICKY_ALARM_EN
  logic unused_clr;
  assign unused_clr = ^bus.alarmClr;
`endif

  // Scan sequencing: request, evaluate, update, then next channel.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= S_IDLE;
      ch        <= 2'd0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= upd && (ch == 2'd3);
      case (state)
        S_IDLE:   if (bus.scanEn) state <= S_REQ;
        S_REQ:    if (bus.sampleAck) state <= S_EVAL;
        S_EVAL:   state <= S_UPDATE;
        S_UPDATE: begin
          ch    <= ch + 2'd1;
          state <= bus.scanEn ? S_REQ : S_IDLE;
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Calibration table; writes are accepted in every state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 4; i++) begin
        base_tbl[i] <= 5'd20;
        coef_tbl[i] <= 4'd1;
      end
    end else if (bus.cfgWe) begin
      base_tbl[bus.cfgCh] <= bus.cfgBase;
      coef_tbl[bus.cfgCh] <= bus.cfgCoef;
    end
  end

  // Datapath operands, loaded on the accepted sample and held until the next.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      dp_base  <= 5'd0;
      dp_coef  <= 4'd0;
      dp_value <= 4'd0;
    end else if (take) begin
      dp_base  <= base_tbl[ch];
      dp_coef  <= coef_tbl[ch];
      dp_value <= bus.sampleData;
    end
  end

  // One-hot of the channel being updated this cycle.
  always_comb begin
    sel_ch = 4'b0000;
    if (upd) sel_ch[ch] = 1'b1;
  end

  // Debounce: three disagreeing samples in a row flip the alarm.
  always_comb begin
    alarm_nxt = alarm;
    for (int i = 0; i < 4; i++) cnt_nxt[i] = cnt[i];
    for (int i = 0; i < 4; i++) begin
`ifdef STICKY_ALARM_EN
      if (sel_ch[i] && !alarm[i] && bus.dpAbnormality && (cnt[i] == 2'd2)) begin
        alarm_nxt[i] = 1'b1;
        cnt_nxt[i]   = 2'd0;
      end else if (bus.alarmClr[i]) begin
        alarm_nxt[i] = 1'b0;
        cnt_nxt[i]   = 2'd0;
      end else if (sel_ch[i] && !alarm[i]) begin
        cnt_nxt[i] = bus.dpAbnormality ? cnt[i] + 2'd1 : 2'd0;
      end
`else
      if (sel_ch[i]) begin
        if (bus.dpAbnormality == alarm[i]) begin
          cnt_nxt[i] = 2'd0;
        end else if (cnt[i] == 2'd2) begin
          alarm_nxt[i] = ~alarm[i];
          cnt_nxt[i]   = 2'd0;
        end else begin
          cnt_nxt[i] = cnt[i] + 2'd1;
        end
      end
`endif
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      alarm <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt[i] <= 2'd0;
    end else begin
      alarm <= alarm_nxt;
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
    end
  end

endmodule

// File: tb/tb_temp_scan_scheduler.sv
// Bench for temp_scan_scheduler: sensor driver, reference model, scoreboard
// queues and a handshake monitor. Honors STICKY_ALARM_EN like the design.
module tb_temp_scan_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  temp_scan_scheduler_if bus();

  temp_scan_scheduler dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  logic [1:0] m_ch;
  logic [4:0] m_base [4];
  logic [3:0] m_coef [4];
  logic [3:0] m_alarm;
  int         m_run  [4];
  logic [4:0] m_dp_base;
  logic [3:0] m_dp_coef;
  logic [3:0] m_dp_data;

  // scoreboard: {ch, base, coef, data} and {scanDone, alarm}
  logic [14:0] exp_dp_q [$];
  logic [4:0]  exp_al_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ch = 2'd0;
    m_alarm = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_base[i] = 5'd20;
      m_coef[i] = 4'd1;
      m_run[i]  = 0;
    end
    m_dp_base = 5'd0;
    m_dp_coef = 4'd0;
    m_dp_data = 4'd0;
    exp_dp_q.delete();
    exp_al_q.delete();
  endtask

  // An alarm flips after three consecutive samples that disagree with it.
  function automatic void model_sample(input logic [1:0] c, input logic s);
`ifdef STICKY_ALARM_EN
    if (m_alarm[c]) return;
`endif
    if (s != m_alarm[c]) begin
      m_run[c] = m_run[c] + 1;
      if (m_run[c] == 3) begin
        m_alarm[c] = ~m_alarm[c];
        m_run[c] = 0;
      end
    end else begin
      m_run[c] = 0;
    end
  endfunction

  // ---------------- monitor ----------------
  logic [2:0] hs_sr;
  always @(posedge clk or negedge rstN) begin
    if (!rstN) hs_sr <= 3'b000;
    else       hs_sr <= {hs_sr[1:0], bus.sampleReq && bus.sampleAck};
  end

  initial begin : monitor
    logic [14:0] e;
    logic [4:0]  a;
    forever begin
      @(negedge clk);
      if (rstN) begin
        if (hs_sr[0]) begin
          if (exp_dp_q.size() == 0) begin
            check("dp_unexpected", 32'(1), 32'(0));
          end else begin
            e = exp_dp_q.pop_front();
            check("dp_ch",    32'(bus.sampleCh),      32'(e[14:13]));
            check("dp_base",  32'(bus.dpBaseTemp),    32'(e[12:8]));
            check("dp_coef",  32'(bus.dpTempCoef),    32'(e[7:4]));
            check("dp_value", 32'(bus.dpSensorValue), 32'(e[3:0]));
          end
        end
        if (hs_sr[2]) begin
          if (exp_al_q.size() == 0) begin
            check("alarm_unexpected", 32'(1), 32'(0));
          end else begin
            a = exp_al_q.pop_front();
            check("alarm",     32'(bus.alarm),    32'(a[3:0]));
            check("scan_done", 32'(bus.scanDone), 32'(a[4]));
          end
        end else begin
          check("scan_done_quiet", 32'(bus.scanDone), 32'(0));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called and returning at a falling edge; returns in the EVAL cycle.
  task automatic do_sample(input int delay, input logic [3:0] data, input logic abn,
                           input logic wr, input logic [1:0] wr_ch,
                           input logic [4:0] wr_base, input logic [3:0] wr_coef,
                           output int ack_cyc);
    int waited = 0;
    ack_cyc = 0;
    while (!bus.sampleReq && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.sampleReq) begin
      check("req_timeout", 32'(0), 32'(1));
      return;
    end
    check("req_ch", 32'(bus.sampleCh), 32'(m_ch));
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      check("req_hold", 32'({bus.sampleReq, bus.sampleCh}), 32'({1'b1, m_ch}));
    end
    bus.sampleAck     = 1'b1;
    bus.sampleData    = data;
    bus.dpAbnormality = abn;
    ack_cyc = cyc;
    exp_dp_q.push_back({m_ch, m_base[m_ch], m_coef[m_ch], data});
    m_dp_base = m_base[m_ch];
    m_dp_coef = m_coef[m_ch];
    m_dp_data = data;
    model_sample(m_ch, abn);
    exp_al_q.push_back({m_ch == 2'd3, m_alarm});
    if (wr) begin
      bus.cfgWe   = 1'b1;
      bus.cfgCh   = wr_ch;
      bus.cfgBase = wr_base;
      bus.cfgCoef = wr_coef;
      m_base[wr_ch] = wr_base;
      m_coef[wr_ch] = wr_coef;
    end
    m_ch = m_ch + 2'd1;
    @(negedge clk);
    bus.sampleAck = 1'b0;
    bus.cfgWe     = 1'b0;
  endtask

  task automatic simple_sample(input int delay, input logic [3:0] data, input logic abn);
    int c;
    do_sample(delay, data, abn, 1'b0, 2'd0, 5'd0, 4'd0, c);
  endtask

  task automatic cfg_write(input logic [1:0] c, input logic [4:0] b, input logic [3:0] k);
    bus.cfgWe = 1'b1; bus.cfgCh = c; bus.cfgBase = b; bus.cfgCoef = k;
    m_base[c] = b;
    m_coef[c] = k;
    @(negedge clk);
    bus.cfgWe = 1'b0;
  endtask

  // One full pass over channels 0..3; only channel 1 sees abnormality a1.
  task automatic run_scan(input logic a1);
    for (int k = 0; k < 4; k++)
      simple_sample(0, 4'($urandom_range(0, 15)), (m_ch == 2'd1) ? a1 : 1'b0);
  endtask

  task automatic drain();
    bus.scanEn = 1'b0;
    repeat (6) @(negedge clk);
    check("drain_dp_q", 32'(exp_dp_q.size()), 32'(0));
    check("drain_al_q", 32'(exp_al_q.size()), 32'(0));
  endtask

  task automatic clr_pulse(input logic [3:0] mask);
    bus.alarmClr = mask;
`ifdef STICKY_ALARM_EN
    for (int i = 0; i < 4; i++)
      if (mask[i]) begin
        m_alarm[i] = 1'b0;
        m_run[i] = 0;
      end
`endif
    @(negedge clk);
    bus.alarmClr = 4'b0000;
    check("alarm_after_clr", 32'(bus.alarm), 32'(m_alarm));
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  // ---------------- main stimulus ----------------
  initial begin : main
    int ac, prev_ac;
    rstN = 1'b0;
    bus.scanEn = 1'b0; bus.cfgWe = 1'b0; bus.cfgCh = 2'd0;
    bus.cfgBase = 5'd0; bus.cfgCoef = 4'd0; bus.sampleAck = 1'b0;
    bus.sampleData = 4'd0; bus.dpAbnormality = 1'b0; bus.alarmClr = 4'b0000;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_req",   32'(bus.sampleReq),     32'(0));
    check("rst_done",  32'(bus.scanDone),      32'(0));
    check("rst_alarm", 32'(bus.alarm),         32'(0));
    check("rst_base",  32'(bus.dpBaseTemp),    32'(0));
    check("rst_coef",  32'(bus.dpTempCoef),    32'(0));
    check("rst_value", 32'(bus.dpSensorValue), 32'(0));
    rstN = 1'b1;

    // continuous scan with immediate acks: one channel every 3 cycles
    bus.scanEn = 1'b1;
    prev_ac = 0;
    for (int i = 0; i < 8; i++) begin
      do_sample(0, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 2'd0, 5'd0, 4'd0, ac);
      if (i > 0) check("ack_period", 32'(ac - prev_ac), 32'(3));
      prev_ac = ac;
    end

    // calibration entry reaches the datapath for its channel
    cfg_write(2'd2, 5'd31, 4'd7);
    while (m_ch != 2'd2) simple_sample(0, 4'($urandom_range(0, 15)), 1'b0);
    simple_sample(1, 4'd9, 1'b0);
    check("cal_base",  32'(bus.dpBaseTemp),    32'(31));
    check("cal_coef",  32'(bus.dpTempCoef),    32'(7));
    check("cal_value", 32'(bus.dpSensorValue), 32'(9));
    drain();

    // debounce: alarm[1] rises only on the third consecutive abnormal scan
    do_reset();
    bus.scanEn = 1'b1;
    run_scan(1'b1);
    run_scan(1'b1);
    check("alarm1_after_2", 32'(bus.alarm[1]), 32'(0));
    run_scan(1'b1);
    check("alarm1_after_3", 32'(bus.alarm[1]), 32'(1));
    drain();
`ifdef STICKY_ALARM_EN
    clr_pulse(4'b0001);
`else
    clr_pulse(4'b0010);
    check("clr_ignored", 32'(bus.alarm[1]), 32'(1));
`endif
    bus.scanEn = 1'b1;
    run_scan(1'b0);
    run_scan(1'b0);
    run_scan(1'b0);
`ifdef STICKY_ALARM_EN
    check("sticky_hold", 32'(bus.alarm[1]), 32'(1));
    drain();
    clr_pulse(4'b0010);
    check("sticky_clr", 32'(bus.alarm[1]), 32'(0));
`else
    check("normal_clear", 32'(bus.alarm[1]), 32'(0));
    drain();
`endif

    // 1,1,0,1 never reaches three in a row
    do_reset();
    bus.scanEn = 1'b1;
    run_scan(1'b1);
    run_scan(1'b1);
    run_scan(1'b0);
    run_scan(1'b1);
    check("alarm1_broken_run", 32'(bus.alarm[1]), 32'(0));

    // delayed ack, then scanEn drop during EVAL and resume at the next channel
    simple_sample(5, 4'($urandom_range(0, 15)), 1'b0);
    bus.scanEn = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_after_drop", 32'(bus.sampleReq), 32'(0));
    check("ch_retained", 32'(bus.sampleCh), 32'(m_ch));
    bus.scanEn = 1'b1;
    simple_sample(2, 4'($urandom_range(0, 15)), 1'b0);
    drain();

    // acks while idle are ignored
    bus.sampleAck = 1'b1;
    bus.sampleData = 4'($urandom_range(0, 15));
    repeat (3) @(negedge clk);
    bus.sampleAck = 1'b0;
    check("idle_ack_base",  32'(bus.dpBaseTemp),    32'(m_dp_base));
    check("idle_ack_coef",  32'(bus.dpTempCoef),    32'(m_dp_coef));
    check("idle_ack_value", 32'(bus.dpSensorValue), 32'(m_dp_data));
    check("idle_ack_req",   32'(bus.sampleReq),     32'(0));

    // randomized scan with random ack delay, data, abnormality and table writes
    bus.scanEn = 1'b1;
    for (int i = 0; i < 200; i++) begin
      do_sample($urandom_range(0, 3), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), ac);
    end
    drain();

    // reset during a pending request drops it at once; restart at channel 0
    bus.scanEn = 1'b1;
    while (m_ch != 2'd2) simple_sample(0, 4'($urandom_range(0, 15)), 1'b0);
    repeat (2) @(negedge clk);
    check("req_before_rst", 32'(bus.sampleReq), 32'(1));
    #2;
    rstN = 1'b0;
    #1;
    check("req_async_rst",   32'(bus.sampleReq), 32'(0));
    check("alarm_async_rst", 32'(bus.alarm),     32'(0));
    model_reset();
    @(negedge clk);
    rstN = 1'b1;
    simple_sample(0, 4'($urandom_range(0, 15)), 1'b0);
    simple_sample(1, 4'($urandom_range(0, 15)), 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/temp_scan_scheduler.md
TEMP_SCAN_SCHEDULER -- requirements
Module: temp_scan_scheduler

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rstN  input  1  asynchronous, active-low reset.
REQ-003 scanEn  input  1  high = run continuous round-robin scan of channels 0..3.
REQ-004 cfgWe  input  1  calibration-table write strobe.
REQ-005 cfgCh  input  2  channel index for the calibration write.
REQ-006 cfgBase  input  5  factory base temperature written to channel cfgCh.
REQ-007 cfgCoef  input  4  factory temperature coefficient written to channel cfgCh.
REQ-008 sampleReq  output  1  sensor sample request, held high until acknowledged.
REQ-009 sampleCh  output  2  channel being requested; stable while sampleReq is high.
REQ-010 sampleAck  input  1  sensor acknowledge; sampleData is valid in the same cycle.
REQ-011 sampleData  input  4  raw sensor value.
REQ-012 dpBaseTemp  output  5  registered base temperature to the shared abnormality datapath.
REQ-013 dpTempCoef  output  4  registered coefficient to the datapath.
REQ-014 dpSensorValue  output  4  registered sensor value to the datapath.
REQ-015 dpAbnormality  input  1  combinational abnormality result from the datapath.
REQ-016 alarmClr  input  4  per-channel alarm clear pulse; used only when the macro is defined.
REQ-017 alarm  output  4  debounced per-channel alarm.
REQ-018 scanDone  output  1  one-cycle pulse after channel 3 is updated.

Function
REQ-019 FSM states:
- IDLE -> REQ when scanEn=1.
- REQ -> EVAL on the cycle sampleAck=1.
- EVAL -> UPDATE unconditionally (one cycle).
- UPDATE -> REQ if scanEn=1, else -> IDLE.
REQ-020 In REQ, sampleReq=1 and sampleCh=ch; sampleReq=0 in all other states.
REQ-021 On the REQ->EVAL edge, load the dp* registers:
- dpSensorValue = sampleData.
- dpBaseTemp and dpTempCoef = table[ch], using table contents from before any same-cycle write.
REQ-022 dp* outputs hold their value until the next REQ->EVAL edge.
REQ-023 In UPDATE, sample dpAbnormality for channel ch, update that channel's debounce state, then advance ch = (ch+1) mod 4 (3 wraps to 0).
REQ-024 scanDone=1 for exactly the cycle after an UPDATE of channel 3.
REQ-025 Debounce uses one 2-bit counter per channel:
- A sample equal to alarm[ch] clears the counter.
- A sample differing from alarm[ch] increments the counter.
- When the counter reaches 3, alarm[ch] toggles and the counter clears.
REQ-026 The calibration table is 4 x (5+4) bits; a cfgWe write takes effect on the next clock edge in any state.
REQ-027 If scanEn drops mid-channel, the current channel completes through UPDATE, then the FSM goes to IDLE with ch retained; a later scan resumes at ch.
REQ-028 sampleAck outside REQ is ignored.
REQ-029 Latency from the ack edge to the alarm change is 2 cycles.

Reset
REQ-030 rstN=0 asynchronously forces:
- state = IDLE, ch = 0, sampleReq = 0, scanDone = 0.
- dp* outputs = 0, alarm = 4'b0000, all counters = 0.
- table entries = base 5'd20, coef 4'd1.
REQ-031 Reset asserted mid-handshake abandons the sample; the first request after release is for channel 0.

Configuration
REQ-032 Macro STICKY_ALARM_EN, when defined:
- A set alarm ignores normal samples and clears only on alarmClr[i]=1, which also clears counter i.
- If alarmClr[i] and the alarm-set event for channel i occur in the same cycle, the set wins.
REQ-033 Without STICKY_ALARM_EN, alarmClr is ignored and alarms clear only through the REQ-025 debounce.

Verification
REQ-034 Reset, then scanEn=1 with sampleAck tied high -> sampleCh sequence 0,1,2,3,0 every 3 cycles; scanDone pulses once per 12 cycles.
REQ-035 Write cfgCh=2, base 5'd31, coef 4'd7; ack channel 2 with data 4'd9 -> dpBaseTemp=31, dpTempCoef=7, dpSensorValue=9 in the EVAL cycle.
REQ-036 dpAbnormality=1 for channel 1 on 3 consecutive scans -> alarm[1] rises after the 3rd UPDATE, not the 2nd; the sequence 1,1,0,1 keeps alarm[1]=0.
REQ-037 Without the macro, with alarm[1]=1, three normal samples clear alarm[1]. With STICKY_ALARM_EN, alarm[1] stays 1 until a one-cycle alarmClr=4'b0010.
REQ-038 Delay sampleAck 5 cycles -> sampleReq and sampleCh stay stable; dropping scanEn during EVAL -> UPDATE completes, then IDLE, and the next scan resumes at the next channel.
REQ-039 Assert rstN=0 while sampleReq=1 -> sampleReq falls immediately (no clock); after release, the first sampleCh is 0.
